// File: rtl/transform_pkg.sv
// Shared definitions for the forward/inverse view transforms.
// Contents: float constants, FSM state encodings, sign flip, 32-step sin/cos
// lookup and a small float rounding/packing helper used by the float IP models.
package transform_pkg;

    localparam logic [31:0] FP_ONE       = 32'h3f80_0000;
    localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
    localparam logic [31:0] DIST_DEFAULT = 32'h3f80_0000;

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_FLUSH = 3'd0;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd1;
    localparam logic [STATE_W-1:0] ST_MUL   = 3'd2;
    localparam logic [STATE_W-1:0] ST_ADD   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    // Negation by sign-bit flip only.
    function automatic logic [31:0] fneg(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

    // sin(k * 11.25 deg) for k = 0..8 (first quadrant).
    function automatic logic [31:0] sin_quarter(input logic [3:0] k);
        logic [31:0] v;
        case (k)
            4'd0:    v = FP_ZERO;
            4'd1:    v = 32'h3e47_c5c2;
            4'd2:    v = 32'h3ec3_ef15;
            4'd3:    v = 32'h3f0e_39da;
            4'd4:    v = 32'h3f35_04f3;
            4'd5:    v = 32'h3f54_db31;
            4'd6:    v = 32'h3f6c_835e;
            4'd7:    v = 32'h3f7b_14be;
            default: v = FP_ONE;
        endcase
        return v;
    endfunction

    // Full-turn sine by quadrant folding; zeros stay +0.
    function automatic logic [31:0] sin_lut(input logic [4:0] idx);
        logic [3:0]  k;
        logic [31:0] v;
        k = idx[3] ? (4'd8 - {1'b0, idx[2:0]}) : {1'b0, idx[2:0]};
        v = sin_quarter(k);
        if (idx[4] && (v != FP_ZERO)) v = fneg(v);
        return v;
    endfunction

    // cos(x) = sin(x + 90 deg); the 5-bit add wraps at a full turn.
    function automatic logic [31:0] cos_lut(input logic [4:0] idx);
        return sin_lut(idx + 5'd8);
    endfunction

    // Round-to-nearest-even and pack. n = {frac[22:0], guard, round, sticky}.
    function automatic logic [31:0] fp_pack(input logic s, input logic [8:0] e,
                                            input logic [25:0] n);
        logic [23:0] m;
        logic [8:0]  ex;
        logic        up;
        ex = e;
        up = n[2] & (n[1] | n[0] | n[3]);
        m  = {1'b0, n[25:3]} + 24'(up);
        if (m[23]) begin
            ex = ex + 9'd1;
            m  = 24'd0;
        end
        if (ex >= 9'd255) return {s, 8'hff, 23'd0};
        if (ex == 9'd0)   return {s, 31'd0};
        return {s, ex[7:0], m[22:0]};
    endfunction

endpackage

// File: rtl/adder.sv
// Single-precision float adder model with a fixed-latency valid pipeline.
// No reset: stale contents must be drained by the user.
// Ports: clk_i; a_valid_i/a_i, b_valid_i/b_i operands; res_valid_o/res_o result.
module adder
    import transform_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        a_valid_i,
    input  logic [31:0] a_i,
    input  logic        b_valid_i,
    input  logic [31:0] b_i,
    output logic        res_valid_o,
    output logic [31:0] res_o
);

    logic [LATENCY-1:0]       vld_q;
    logic [LATENCY-1:0][31:0] dat_q;

    // Three guard bits on alignment; exact cancellation yields +0.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big;
        logic [31:0] sml;
        logic [7:0]  d;
        logic [26:0] mb;
        logic [26:0] ms;
        logic [26:0] diff;
        logic [27:0] sum;
        int          lead;
        int          lz;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 3'b000};
        ms = (d > 8'd26) ? 27'd0 : ({1'b1, sml[22:0], 3'b000} >> d);
        if (big[31] == sml[31]) begin
            sum = {1'b0, mb} + {1'b0, ms};
            return fp_pack(big[31], {1'b0, big[30:23]} + 9'(sum[27]),
                           sum[27] ? sum[26:1] : sum[25:0]);
        end
        diff = mb - ms;
        if (diff == 27'd0) return FP_ZERO;
        lead = 0;
        for (int i = 0; i < 27; i++) begin
            if (diff[i]) lead = i;
        end
        lz = 26 - lead;
        if (lz >= int'(big[30:23])) return {big[31], 31'd0};
        return fp_pack(big[31], {1'b0, big[30:23]} - 9'(lz), 26'(diff << lz));
    endfunction

    always_ff @(posedge clk_i) begin
        vld_q[0] <= a_valid_i & b_valid_i;
        dat_q[0] <= fp_add(a_i, b_i);
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign res_valid_o = vld_q[LATENCY-1];
    assign res_o       = dat_q[LATENCY-1];

endmodule

// File: rtl/multiplier.sv
// Single-precision float multiplier model with a fixed-latency valid pipeline.
// No reset: stale contents must be drained by the user.
// Ports: clk_i; a_valid_i/a_i, b_valid_i/b_i operands; res_valid_o/res_o result.
module multiplier
    import transform_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        a_valid_i,
    input  logic [31:0] a_i,
    input  logic        b_valid_i,
    input  logic [31:0] b_i,
    output logic        res_valid_o,
    output logic [31:0] res_o
);

    logic [LATENCY-1:0]       vld_q;
    logic [LATENCY-1:0][31:0] dat_q;

    // Denormal inputs are treated as zero; no NaN special-casing.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [46:0] pn;
        logic [9:0]  e;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) return {s, 31'd0};
        p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        pn = p[47] ? p[46:0] : {p[45:0], 1'b0};
        e  = 10'(a[30:23]) + 10'(b[30:23]) + 10'(p[47]);
        if (e <= 10'd127) return {s, 31'd0};
        if (e >= 10'd382) return {s, 8'hff, 23'd0};
        return fp_pack(s, 9'(e - 10'd127), {pn[46:23], pn[22], |pn[21:0]});
    endfunction

    always_ff @(posedge clk_i) begin
        vld_q[0] <= a_valid_i & b_valid_i;
        dat_q[0] <= fp_mul(a_i, b_i);
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign res_valid_o = vld_q[LATENCY-1];
    assign res_o       = dat_q[LATENCY-1];

endmodule

// File: rtl/inverse_transformation.sv
// View-space to world-space point transform: y -= DIST, then inverse yaw
// rotation about y, sequenced through one shared float multiplier and adder.
// Ports: clk_in, rst_in (sync, active high); yaw/pos/valid_in request;
// ready_out accept window; valid_out one-cycle pulse with new_pos result.
module inverse_transformation
    import transform_pkg::*;
#(
    parameter logic [31:0] DIST         = DIST_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [4:0]       yaw,
    input  logic [3:0][31:0] pos,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [3:0][31:0] new_pos
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               issued_q, issued_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [3:0][31:0]   new_pos_q, new_pos_d;
    logic               mul_valid_q, mul_valid_d;
    logic               add_valid_q, add_valid_d;

    logic [3:0][31:0]   pos_q, pos_d;
    logic [31:0]        sin_q, sin_d;
    logic [31:0]        cos_q, cos_d;
    logic [3:0][31:0]   m_q, m_d;
    logic [1:0][31:0]   r_q, r_d;
    logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]        add_a_q, add_a_d, add_b_q, add_b_d;

    logic               mul_res_valid, add_res_valid;
    logic [31:0]        mul_res, add_res;

    multiplier #(.LATENCY(3)) u_mul (
        .clk_i       (clk_in),
        .a_valid_i   (mul_valid_q),
        .a_i         (mul_a_q),
        .b_valid_i   (mul_valid_q),
        .b_i         (mul_b_q),
        .res_valid_o (mul_res_valid),
        .res_o       (mul_res)
    );

    adder #(.LATENCY(2)) u_add (
        .clk_i       (clk_in),
        .a_valid_i   (add_valid_q),
        .a_i         (add_a_q),
        .b_valid_i   (add_valid_q),
        .b_i         (add_b_q),
        .res_valid_o (add_res_valid),
        .res_o       (add_res)
    );

    // Next-state and datapath: each op issues for one cycle, then waits for its result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        issued_d    = issued_q;
        valid_d     = 1'b0;
        new_pos_d   = new_pos_q;
        mul_valid_d = 1'b0;
        add_valid_d = 1'b0;
        pos_d       = pos_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        m_d         = m_q;
        r_d         = r_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;

        case (state_q)
            ST_FLUSH: begin
                // IP outputs ignored here: stale results from before reset drain out.
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) state_d = ST_IDLE;
                else                                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_IDLE: begin
                if (valid_in && ready_q) begin
                    pos_d    = pos;
                    sin_d    = sin_lut(yaw);
                    cos_d    = cos_lut(yaw);
                    idx_d    = 2'd0;
                    issued_d = 1'b0;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                if (!issued_q) begin
                    mul_valid_d = 1'b1;
                    issued_d    = 1'b1;
                    case (idx_q)
                        2'd0:    begin mul_a_d = pos_q[0]; mul_b_d = cos_q; end
                        2'd1:    begin mul_a_d = pos_q[2]; mul_b_d = sin_q; end
                        2'd2:    begin mul_a_d = pos_q[0]; mul_b_d = sin_q; end
                        default: begin mul_a_d = pos_q[2]; mul_b_d = cos_q; end
                    endcase
                end else if (mul_res_valid) begin
                    m_d[idx_q] = mul_res;
                    issued_d   = 1'b0;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = ST_ADD;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_ADD: begin
                if (!issued_q) begin
                    add_valid_d = 1'b1;
                    issued_d    = 1'b1;
                    case (idx_q)
                        2'd0:    begin add_a_d = m_q[0];   add_b_d = fneg(m_q[1]); end
                        2'd1:    begin add_a_d = m_q[2];   add_b_d = m_q[3];       end
                        default: begin add_a_d = pos_q[1]; add_b_d = fneg(DIST);   end
                    endcase
                end else if (add_res_valid) begin
                    issued_d = 1'b0;
                    if (idx_q == 2'd2) begin
                        // Result registered on entry to DONE so valid_out lines up with DONE.
                        new_pos_d = {pos_q[3], r_q[1], add_res, r_q[0]};
                        valid_d   = 1'b1;
                        idx_d     = 2'd0;
                        state_d   = ST_DONE;
                    end else begin
                        r_d[idx_q[0]] = add_res;
                        idx_d         = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_FLUSH;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            issued_q    <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            new_pos_q   <= '0;
            mul_valid_q <= 1'b0;
            add_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            issued_q    <= issued_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            new_pos_q   <= new_pos_d;
            mul_valid_q <= mul_valid_d;
            add_valid_q <= add_valid_d;
        end
    end

    // Operand and temporary registers; only meaningful under the control state.
    always_ff @(posedge clk_in) begin
        pos_q   <= pos_d;
        sin_q   <= sin_d;
        cos_q   <= cos_d;
        m_q     <= m_d;
        r_q     <= r_d;
        mul_a_q <= mul_a_d;
        mul_b_q <= mul_b_d;
        add_a_q <= add_a_d;
        add_b_q <= add_b_d;
    end

    assign ready_out = ready_q;
    assign valid_out = valid_q;
    assign new_pos   = new_pos_q;

endmodule

// File: tb/tb_inverse_transformation.sv
// Scoreboard bench for inverse_transformation: stimulus pushes expected
// results, a negedge monitor pops and compares on every valid_out.
module tb_inverse_transformation;

    localparam int unsigned FLUSH = 16;
    localparam int unsigned TMO   = 400;

    typedef logic [3:0][31:0] vec_t;

    logic       clk_in;
    logic       rst_in;
    logic [4:0] yaw;
    vec_t       pos;
    logic       valid_in;
    logic       ready_out;
    logic       valid_out;
    vec_t       new_pos;

    vec_t exp_q[$];
    vec_t mon_exp;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_valid = 1'b0;

    // Point {w, z, y, x} and hand-computed world-space results.
    localparam vec_t P1   = {32'h3f800000, 32'h40000000, 32'h3f800000, 32'h3f800000};
    localparam vec_t P2   = {32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h40000000};
    localparam vec_t E0   = {32'h3f800000, 32'h40000000, 32'h00000000, 32'h3f800000};
    localparam vec_t E8   = {32'h3f800000, 32'h3f800000, 32'h00000000, 32'hc0000000};
    localparam vec_t E16  = {32'h3f800000, 32'hc0000000, 32'h00000000, 32'hbf800000};
    localparam vec_t E16B = {32'h3f800000, 32'hbf800000, 32'h00000000, 32'hc0000000};

    inverse_transformation #(
        .DIST         (32'h3f800000),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .yaw       (yaw),
        .pos       (pos),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .new_pos   (new_pos)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            @(negedge clk_in);
            if (ready_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got ready_out=0 for %0d cycles, required 1", TMO);
        end
    endtask

    task automatic send(input logic [4:0] y, input vec_t p, input vec_t e);
        wait_ready();
        yaw      = y;
        pos      = p;
        valid_in = 1'b1;
        exp_q.push_back(e);
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    // ready_out must rise exactly FLUSH clocks after reset release.
    task automatic flush_check(input string tag);
        for (int i = 1; i <= int'(FLUSH) + 2; i++) begin
            @(posedge clk_in);
            #1;
            chk(tag, 128'(ready_out), 128'(i >= int'(FLUSH)));
            chk({tag, "_valid"}, 128'(valid_out), 128'(0));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < int'(TMO); i++) begin
            @(negedge clk_in);
            if (exp_q.size() == 0) break;
        end
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor: every valid_out must be a single-cycle pulse carrying the next expected result.
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            chk("pulse_width", 128'(prev_valid), 128'(0));
            chk("ready_during_valid", 128'(ready_out), 128'(0));
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid_out: got new_pos=%h, required no output", new_pos);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("new_pos", 128'(new_pos), 128'(mon_exp));
            end
        end
        prev_valid = valid_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        yaw      = 5'd0;
        pos      = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid_out", 128'(valid_out), 128'(0));
        chk("rst_ready_out", 128'(ready_out), 128'(0));
        chk("rst_new_pos", 128'(new_pos), 128'(0));
        rst_in = 1'b0;
        flush_check("flush_ready");

        send(5'd0,  P1, E0);
        send(5'd8,  P1, E8);
        send(5'd16, P1, E16);
        drain();

        // valid_in held high; inputs changed while busy must not leak into the first result.
        wait_ready();
        yaw      = 5'd0;
        pos      = P1;
        valid_in = 1'b1;
        exp_q.push_back(E0);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("busy_ready", 128'(ready_out), 128'(0));
        yaw = 5'd16;
        pos = P2;
        exp_q.push_back(E16B);
        wait_ready();
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        chk("busy_ready_2", 128'(ready_out), 128'(0));
        drain();

        // Reset while multiplies are in flight: request dropped, stale IP output ignored.
        wait_ready();
        yaw      = 5'd5;
        pos      = P2;
        valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("midrst_ready", 128'(ready_out), 128'(0));
        rst_in = 1'b0;
        flush_check("reflush_ready");
        send(5'd0, P1, E0);
        drain();

        repeat (5) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
